// File: rtl/top_k_feeder.sv
// Upstream stage of the top-k chain: unpacks wide AXI-Stream beats into one integer
// per handshake and clears the chain before each query's first integer.
module top_k_feeder #(
  parameter int IN_WIDTH     = 512,
  parameter int INTEGER_SIZE = 32,
  parameter int CLEAR_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [IN_WIDTH-1:0]     s_axis_tdata,
  input  logic [IN_WIDTH/8-1:0]   s_axis_tkeep,
  input  logic                    s_axis_tvalid,
  input  logic                    s_axis_tlast,
  output logic                    s_axis_tready,
  output logic [INTEGER_SIZE-1:0] m_axis_tdata,
  output logic                    m_axis_tvalid,
  output logic                    m_axis_tlast,
  input  logic                    m_axis_tready,
  output logic                    clear_out,
  output logic [31:0]             query_count,
  output logic                    query_done
);

  localparam int LANES = IN_WIDTH / INTEGER_SIZE;
  localparam int BPL   = INTEGER_SIZE / 8;
  localparam int IW    = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int CW    = $clog2(CLEAR_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, CLEAR, STREAM} state_t;

  state_t                  state_reg;
  logic [IN_WIDTH-1:0]     buf_data_reg;
  logic [LANES-1:0]        buf_valid_reg;
  logic                    buf_last_reg;
  logic                    buf_full_reg;
  logic [IW-1:0]           buf_hi_reg;
  logic [IW-1:0]           idx_reg;
  logic [CW-1:0]           clr_cnt_reg;
  logic [31:0]             running_reg;
  logic [31:0]             query_count_reg;
  logic                    query_done_reg;

  logic [LANES-1:0]        in_valid;
  logic [IW-1:0]           in_hi;
  logic                    in_keep_beat;
  logic [INTEGER_SIZE-1:0] buf_lane [LANES];
  logic                    at_hi, out_hs, last_hs, in_hs, streaming;

  // Invalid lanes read as zero, so a keep-less last beat emits a harmless 0.
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    assign in_valid[gi] = &s_axis_tkeep[gi*BPL +: BPL];
    assign buf_lane[gi] = buf_valid_reg[gi] ? buf_data_reg[gi*INTEGER_SIZE +: INTEGER_SIZE]
                                            : '0;
  end

  always_comb begin
    in_hi = '0;
    for (int i = 1; i < LANES; i++)
      if (in_valid[i]) in_hi = IW'(i);
  end

  // Empty non-last beats never occupy the buffer; empty last beats still close the query.
  assign in_keep_beat = (|in_valid) || s_axis_tlast;

  assign streaming     = (state_reg == STREAM);
  assign at_hi         = (idx_reg == buf_hi_reg);
  assign m_axis_tvalid = streaming && buf_full_reg;
  assign m_axis_tdata  = buf_lane[idx_reg];
  assign m_axis_tlast  = m_axis_tvalid && buf_last_reg && at_hi;
  assign out_hs        = m_axis_tvalid && m_axis_tready;
  assign last_hs       = out_hs && at_hi;
  assign clear_out     = (state_reg == CLEAR);
  assign s_axis_tready = rst_n && ((state_reg == IDLE) ||
                         (streaming && (!buf_full_reg || (last_hs && !buf_last_reg))));
  assign in_hs         = s_axis_tvalid && s_axis_tready;
  assign query_count   = query_count_reg;
  assign query_done    = query_done_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      buf_data_reg    <= '0;
      buf_valid_reg   <= '0;
      buf_last_reg    <= 1'b0;
      buf_full_reg    <= 1'b0;
      buf_hi_reg      <= '0;
      idx_reg         <= '0;
      clr_cnt_reg     <= '0;
      running_reg     <= '0;
      query_count_reg <= '0;
      query_done_reg  <= 1'b0;
    end else begin
      query_done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (in_hs) begin
            buf_data_reg  <= s_axis_tdata;
            buf_valid_reg <= in_valid;
            buf_last_reg  <= s_axis_tlast;
            buf_hi_reg    <= in_hi;
            buf_full_reg  <= in_keep_beat;
            clr_cnt_reg   <= CW'(CLEAR_CYCLES);
            state_reg     <= CLEAR;
          end
        end
        CLEAR: begin
          clr_cnt_reg <= clr_cnt_reg - 1'b1;
          if (clr_cnt_reg == CW'(1)) begin
            state_reg <= STREAM;
            idx_reg   <= '0;
          end
        end
        STREAM: begin
          if (out_hs) begin
            if (at_hi) begin
              idx_reg      <= '0;
              buf_full_reg <= 1'b0;
              if (buf_last_reg) begin
                query_count_reg <= running_reg + 32'd1;
                query_done_reg  <= 1'b1;
                running_reg     <= '0;
                state_reg       <= IDLE;
              end else begin
                running_reg <= running_reg + 32'd1;
              end
            end else begin
              idx_reg     <= idx_reg + 1'b1;
              running_reg <= running_reg + 32'd1;
            end
          end
          // Reload wins over the drain above so the next beat follows without a bubble.
          if (in_hs) begin
            buf_data_reg  <= s_axis_tdata;
            buf_valid_reg <= in_valid;
            buf_last_reg  <= s_axis_tlast;
            buf_hi_reg    <= in_hi;
            buf_full_reg  <= in_keep_beat;
            idx_reg       <= '0;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
